// File: rtl/rf_pkg.sv
// Shared op codes and constants for the multi-port register file.
package rf_pkg;

    typedef enum logic [2:0] {
        OP_WRITE   = 3'd0,
        OP_CLEAR   = 3'd1,
        OP_INC     = 3'd2,
        OP_SETMSB  = 3'd3,
        OP_LOADIMM = 3'd4
    } rf_op_t;

    localparam int RF_NWP = 2;

endpackage

// File: rtl/rf_wr_unit.sv
// One write port: decodes the op into a target register, a valid flag and the new value.
module rf_wr_unit
    import rf_pkg::*;
#(
    parameter int W       = 8,
    parameter int D       = 3,
    parameter int SAT_INC = 0,
    parameter int IMM_REG = 0
) (
    input  logic         en,
    input  logic [2:0]   op,
    input  logic [D-1:0] waddr,
    input  logic [W-1:0] cur,
    input  logic [W-1:0] wdata,
    input  logic         wflag,
    output logic         valid,
    output logic [D-1:0] target,
    output logic [W-1:0] new_val
);

    localparam logic [D-1:0] IMM_ADDR = IMM_REG[D-1:0];
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

    always_comb begin
        valid   = 1'b0;
        target  = waddr;
        new_val = cur;
        if (en) begin
            case (op)
                OP_WRITE: begin
                    valid   = 1'b1;
                    new_val = wdata;
                end
                OP_CLEAR: begin
                    valid   = 1'b1;
                    new_val = '0;
                end
                OP_INC: begin
                    valid   = 1'b1;
                    new_val = (SAT_INC != 0 && cur == '1) ? cur : cur + ONE;
                end
                OP_SETMSB: begin
                    valid   = 1'b1;
                    new_val = {wflag, cur[W-2:0]};
                end
                OP_LOADIMM: begin
                    valid   = 1'b1;
                    target  = IMM_ADDR;
                    new_val = wdata;
                end
                // Codes 5-7 are reserved and leave everything untouched.
                default: valid = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: storage, write-port arbitration (port 1 wins),
// optional write-to-read bypass and a per-register busy scoreboard.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int W       = 8,
    parameter int D       = 3,
    parameter int NR      = 2,
    parameter int BYPASS  = 1,
    parameter int SAT_INC = 0,
    parameter int IMM_REG = 0,
    parameter int TAP0    = 0,
    parameter int TAP1    = 6
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic [RF_NWP-1:0]             we,
    input  logic [RF_NWP-1:0][2:0]        wop,
    input  logic [RF_NWP-1:0][D-1:0]      waddr,
    input  logic [RF_NWP-1:0][W-1:0]      wdata,
    input  logic [RF_NWP-1:0]             wflag,
    input  logic [NR-1:0][D-1:0]          raddr,
    output logic [NR-1:0][W-1:0]          rdata,
    output logic [W-1:0]                  tap0,
    output logic [W-1:0]                  tap1,
    input  logic                          busy_set,
    input  logic [D-1:0]                  busy_addr,
    output logic [2**D-1:0]               busy
);

    localparam int           NREG      = 2**D;
    localparam logic [D-1:0] TAP0_ADDR = TAP0[D-1:0];
    localparam logic [D-1:0] TAP1_ADDR = TAP1[D-1:0];

    logic [W-1:0]    regs_q [NREG];
    logic [W-1:0]    regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic            wr_valid  [RF_NWP];
    logic [D-1:0]    wr_target [RF_NWP];
    logic [W-1:0]    wr_new    [RF_NWP];

    for (genvar p = 0; p < RF_NWP; p++) begin : g_wr
        rf_wr_unit #(
            .W       (W),
            .D       (D),
            .SAT_INC (SAT_INC),
            .IMM_REG (IMM_REG)
        ) u_wr (
            .en      (we[p]),
            .op      (wop[p]),
            .waddr   (waddr[p]),
            .cur     (regs_q[waddr[p]]),
            .wdata   (wdata[p]),
            .wflag   (wflag[p]),
            .valid   (wr_valid[p]),
            .target  (wr_target[p]),
            .new_val (wr_new[p])
        );
    end

    // Later ports overwrite earlier ones, so port 1 wins a same-register conflict outright.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int p = 0; p < RF_NWP; p++) begin
            if (wr_valid[p]) begin
                regs_d[wr_target[p]] = wr_new[p];
                busy_d[wr_target[p]] = 1'b0;
            end
        end
        if (busy_set) begin
            busy_d[busy_addr] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // regs_d already holds the winning new value, so bypass is just reading it; gated so reset reads 0.
    function automatic logic [W-1:0] rd(input logic [D-1:0] a);
        if (BYPASS != 0 && !Reset) begin
            return regs_d[a];
        end
        return regs_q[a];
    endfunction

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            rdata[i] = rd(raddr[i]);
        end
        tap0 = rd(TAP0_ADDR);
        tap1 = rd(TAP1_ADDR);
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (bypass+wrap, no-bypass+saturate) checked against an array model.
module tb_reg_file_mp;
    import rf_pkg::*;

    typedef logic [7:0] regs_t [8];

    logic            CLK;
    logic            Reset;
    logic [1:0]      we;
    logic [1:0][2:0] wop;
    logic [1:0][2:0] waddr;
    logic [1:0][7:0] wdata;
    logic [1:0]      wflag;
    logic [1:0][2:0] raddr;
    logic            busy_set;
    logic [2:0]      busy_addr;

    logic [1:0][7:0] rdata_a, rdata_b;
    logic [7:0]      tap0_a, tap1_a, tap0_b, tap1_b;
    logic [7:0]      busy_a, busy_b;

    regs_t      mdl_a, mdl_b;
    logic [7:0] busy_m;
    int         checks = 0;
    int         errors = 0;

    reg_file_mp #(.BYPASS(1), .SAT_INC(0)) u_dut_a (
        .CLK(CLK), .Reset(Reset), .we(we), .wop(wop), .waddr(waddr), .wdata(wdata),
        .wflag(wflag), .raddr(raddr), .rdata(rdata_a), .tap0(tap0_a), .tap1(tap1_a),
        .busy_set(busy_set), .busy_addr(busy_addr), .busy(busy_a)
    );

    reg_file_mp #(.BYPASS(0), .SAT_INC(1)) u_dut_b (
        .CLK(CLK), .Reset(Reset), .we(we), .wop(wop), .waddr(waddr), .wdata(wdata),
        .wflag(wflag), .raddr(raddr), .rdata(rdata_b), .tap0(tap0_b), .tap1(tap1_b),
        .busy_set(busy_set), .busy_addr(busy_addr), .busy(busy_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Register contents after the edge, from the op table and the "port 1 wins" rule.
    function automatic regs_t next_regs(input regs_t cur, input bit sat);
        regs_t      nxt;
        int         tgt;
        logic [7:0] old, v;
        nxt = cur;
        for (int p = 0; p < 2; p++) begin
            if (we[p] && wop[p] <= 3'd4) begin
                old = cur[waddr[p]];
                tgt = (wop[p] == 3'd4) ? 0 : int'(waddr[p]);
                case (wop[p])
                    3'd0:    v = wdata[p];
                    3'd1:    v = 8'h00;
                    3'd2:    v = (old == 8'hFF) ? (sat ? 8'hFF : 8'h00) : old + 8'd1;
                    3'd3:    v = {wflag[p], old[6:0]};
                    default: v = wdata[p];
                endcase
                nxt[tgt] = v;
            end
        end
        return nxt;
    endfunction

    function automatic logic [7:0] next_busy();
        logic [7:0] b;
        b = busy_m;
        for (int p = 0; p < 2; p++) begin
            if (we[p] && wop[p] <= 3'd4) begin
                b[(wop[p] == 3'd4) ? 3'd0 : waddr[p]] = 1'b0;
            end
        end
        if (busy_set) b[busy_addr] = 1'b1;
        return b;
    endfunction

    // Called at a negedge with inputs already driven; returns at the following negedge.
    task automatic cycle();
        regs_t      na, nb;
        logic [7:0] nbusy;
        #1;
        na    = next_regs(mdl_a, 1'b0);
        nb    = next_regs(mdl_b, 1'b1);
        nbusy = next_busy();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rdata_byp%0d", i), rdata_a[i], na[raddr[i]]);
            check($sformatf("rdata_nobyp%0d", i), rdata_b[i], mdl_b[raddr[i]]);
        end
        check("tap0_byp", tap0_a, na[0]);
        check("tap1_byp", tap1_a, na[6]);
        check("tap0_nobyp", tap0_b, mdl_b[0]);
        check("tap1_nobyp", tap1_b, mdl_b[6]);
        @(posedge CLK);
        #1;
        mdl_a  = na;
        mdl_b  = nb;
        busy_m = nbusy;
        check("busy_a", busy_a, busy_m);
        check("busy_b", busy_b, busy_m);
        @(negedge CLK);
    endtask

    task automatic idle();
        we       = 2'b00;
        wop      = '0;
        waddr    = '0;
        wdata    = '0;
        wflag    = '0;
        busy_set = 1'b0;
        busy_addr = '0;
    endtask

    task automatic wr(input int p, input logic [2:0] op, input logic [2:0] a,
                      input logic [7:0] d, input logic f);
        we[p]    = 1'b1;
        wop[p]   = op;
        waddr[p] = a;
        wdata[p] = d;
        wflag[p] = f;
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        raddr = '0;
        for (int i = 0; i < 8; i++) begin
            mdl_a[i] = '0;
            mdl_b[i] = '0;
        end
        busy_m = '0;
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        check("busy_after_reset", busy_a, 8'h00);
        cycle();

        // Basic ops
        wr(0, OP_WRITE, 3'd6, 8'h7F, 1'b0); cycle();
        idle(); wr(0, OP_SETMSB, 3'd6, 8'h00, 1'b1); cycle();
        idle(); #1;
        check("setmsb_tap1", tap1_a, 8'hFF);
        wr(0, OP_LOADIMM, 3'd5, 8'h11, 1'b0); raddr = {3'd5, 3'd0}; cycle();
        idle(); #1;
        check("loadimm_r0", rdata_a[0], 8'h11);
        check("loadimm_r5", rdata_a[1], 8'h00);

        // Increment boundary: wrap on instance a, saturate on instance b
        wr(1, OP_WRITE, 3'd2, 8'hFF, 1'b0); cycle();
        idle(); wr(1, OP_INC, 3'd2, 8'h00, 1'b0); cycle();
        idle(); raddr = {3'd2, 3'd2}; #1;
        check("inc_wrap", rdata_a[0], 8'h00);
        check("inc_sat", rdata_b[0], 8'hFF);
        wr(0, OP_WRITE, 3'd2, 8'h41, 1'b0); cycle();
        idle(); wr(0, OP_INC, 3'd2, 8'h00, 1'b0); cycle();
        idle(); #1;
        check("inc_plain", rdata_a[0], 8'h42);

        // Port conflicts
        raddr = {3'd1, 3'd4};
        wr(0, OP_WRITE, 3'd4, 8'h10, 1'b0); wr(1, OP_CLEAR, 3'd4, 8'h00, 1'b0); cycle();
        idle(); wr(1, OP_WRITE, 3'd1, 8'h20, 1'b0); cycle();
        idle(); wr(0, OP_INC, 3'd1, 8'h00, 1'b0); wr(1, OP_WRITE, 3'd1, 8'h33, 1'b0); cycle();
        idle(); #1;
        check("conflict_clear", rdata_a[0], 8'h00);
        check("conflict_inc", rdata_a[1], 8'h33);

        // Bypass vs registered read
        raddr = {3'd0, 3'd3};
        wr(1, OP_WRITE, 3'd3, 8'hA5, 1'b0); #1;
        check("bypass_same", rdata_a[0], 8'hA5);
        check("nobypass_old", rdata_b[0], 8'h00);
        #1; cycle();
        idle(); #1;
        check("nobypass_next", rdata_b[0], 8'hA5);

        // Scoreboard
        busy_set = 1'b1; busy_addr = 3'd7; cycle();
        idle(); #1;
        check("busy_set7", busy_a[7], 1'b1);
        wr(0, OP_WRITE, 3'd7, 8'h01, 1'b0); cycle();
        idle(); #1;
        check("busy_clr7", busy_a[7], 1'b0);
        wr(1, OP_WRITE, 3'd7, 8'h02, 1'b0); busy_set = 1'b1; busy_addr = 3'd7; cycle();
        idle(); #1;
        check("busy_keep7", busy_a[7], 1'b1);
        wr(0, 3'd6, 3'd7, 8'hEE, 1'b1); raddr = {3'd7, 3'd7}; cycle();
        idle(); #1;
        check("reserved_data", rdata_a[0], 8'h02);
        check("reserved_busy", busy_a[7], 1'b1);

        // Mid-cycle reset discards the pending write
        wr(0, OP_WRITE, 3'd3, 8'h5A, 1'b0); raddr = {3'd6, 3'd3};
        #2; Reset = 1'b1; #1;
        check("rst_rdata0", rdata_a[0], 8'h00);
        check("rst_rdata1", rdata_a[1], 8'h00);
        check("rst_tap0", tap0_a, 8'h00);
        check("rst_tap1", tap1_a, 8'h00);
        check("rst_busy", busy_a, 8'h00);
        @(posedge CLK); @(negedge CLK);
        Reset = 1'b0;
        idle();
        for (int i = 0; i < 8; i++) begin
            mdl_a[i] = '0;
            mdl_b[i] = '0;
        end
        busy_m = '0;
        for (int i = 0; i < 8; i += 2) begin
            raddr = {3'(i + 1), 3'(i)};
            cycle();
        end

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            we        = 2'($urandom_range(0, 3));
            wop       = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            waddr     = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            wdata     = {8'($urandom), 8'($urandom)};
            wflag     = 2'($urandom_range(0, 3));
            raddr     = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
            busy_set  = 1'($urandom_range(0, 1));
            busy_addr = 3'($urandom_range(0, 7));
            if (n % 5 == 0) waddr[1] = waddr[0];
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file; successor to the single-write-port datapath register file. Adds NR read ports, two write ports with per-port op codes, optional write-to-read bypass, a per-register busy scoreboard for multi-cycle producers, and a saturating-increment mode. Sits between the decoder/control unit and the ALU; tap outputs feed the accumulator and loop-counter paths directly.

Parameters:
W, 8, data width in bits
D, 3, address width; 2**D registers
NR, 2, number of general read ports
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return registered value only
SAT_INC, 0, 1 = OP_INC saturates at all-ones; 0 = wraps to 0
IMM_REG, 0, destination register of OP_LOADIMM
TAP0, 0, register index driven on tap0
TAP1, 6, register index driven on tap1

Ports:
CLK  in  1  clock, all state updates on posedge
Reset  in  1  asynchronous active-high reset
we  in  2  write enable, bit p for write port p
wop  in  2x3  op code per write port (rf_pkg::rf_op_t)
waddr  in  2xD  destination address per write port (ignored for OP_LOADIMM)
wdata  in  2xW  write data per write port
wflag  in  2  flag bit per port, used by OP_SETMSB
raddr  in  NRxD  read address per read port
rdata  out  NRxW  read data per read port
tap0  out  W  contents of register TAP0
tap1  out  W  contents of register TAP1
busy_set  in  1  mark busy_addr pending
busy_addr  in  D  register to mark pending
busy  out  2**D  per-register pending bit

Behaviour:
- Reset (async, active-high): all registers := 0, busy := 0; rdata/tap0/tap1 read 0 while held. Reset asserted mid-operation discards any write in that cycle.
- Reads combinational. Storage updates on posedge CLK only; write latency 1 cycle.
- Ops per port p when we[p]=1 (new value computed from pre-edge register contents):
  OP_WRITE: R[waddr] := wdata
  OP_CLEAR: R[waddr] := 0
  OP_INC: R[waddr] := R[waddr]+1; wraps 2**W-1 -> 0 if SAT_INC=0; held at 2**W-1 if SAT_INC=1
  OP_SETMSB: R[waddr] := {wflag, R[waddr][W-2:0]}
  OP_LOADIMM: R[IMM_REG] := wdata
  Codes 5-7 reserved: no write, no busy effect.
- Effective target of a port = IMM_REG for OP_LOADIMM, else waddr.
- Both ports target same register: port 1 wins entirely; port 0 dropped (no merging, even for INC+INC).
- Read-modify ops never see the other port's same-cycle write; INC/SETMSB use pre-edge value.
- BYPASS=1: if raddr (or TAPn) matches an effective target with a valid op, rdata returns the winning new value in the same cycle. BYPASS=0: old value until after the edge.
- Scoreboard: busy[a] cleared by any valid write to a; set by busy_set with busy_addr=a. Set and clear same register same cycle: busy stays 1 (new producer issued). busy is informational only; writes are never blocked.

Decomposition:
- rf_pkg: rf_op_t enum (OP_WRITE=0, OP_CLEAR=1, OP_INC=2, OP_SETMSB=3, OP_LOADIMM=4), RF_NWP=2 constant.
- Sub-module rf_wr_unit (one instance per write port): combinational new-value/target/valid from op, pre-edge value, wdata, wflag; SAT_INC passed through. Top holds storage, arbitration, bypass and scoreboard.

Test Plan:
- Reset: write R3=0x5A, assert Reset mid-cycle -> all registers, rdata, tap0, tap1 = 0 immediately; busy = 0.
- Ops: OP_WRITE R6=0x7F; next cycle OP_SETMSB R6 flag=1 -> tap1=0xFF; OP_LOADIMM wdata=0x11 waddr=5 -> R0=0x11, R5 unchanged.
- Increment boundary: R2=0xFF, OP_INC -> 0x00 (SAT_INC=0) / 0xFF (SAT_INC=1); R2=0x41 INC -> 0x42.
- Port conflict: port0 OP_WRITE R4=0x10, port1 OP_CLEAR R4 same cycle -> R4=0x00; port0 INC R1, port1 WRITE R1=0x33 -> R1=0x33.
- Bypass: BYPASS=1, raddr0=3, port1 writes R3=0xA5 -> rdata0=0xA5 same cycle; BYPASS=0 -> old value, 0xA5 next cycle.
- Scoreboard: busy_set R7 -> busy[7]=1 next cycle; write R7 -> busy[7]=0; write R7 plus busy_set R7 same cycle -> busy[7] stays 1; reserved op 6 on R7 -> no change.
